// File: rtl/vq_pkg.sv
// Shared constants and state encoding for the VQ distance search.
package vq_pkg;

  localparam int unsigned NUM_CW_DEF = 16;
  localparam int unsigned DIM_DEF    = 13;
  localparam int unsigned DW_DEF     = 14;

  localparam int unsigned ACC_W = 34;
  localparam int unsigned SUM_W = 40;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } vq_state_e;

endpackage

// File: rtl/vq_sq_acc.sv
// Subtract / square / accumulate pipeline: one coefficient pair per cycle,
// emits a per-codeword sum of squared differences with its index.
module vq_sq_acc
  import vq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DW-1:0]     feat_i,
  input  logic [DW-1:0]     cb_i,
  output logic              done_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int unsigned DIFW = DW + 1;
  localparam int unsigned SQW  = 2 * DW + 2;

  logic signed [DIFW-1:0] diff_d, diff_q;
  logic signed [SQW-1:0]  diff_ext_c, prod_c;
  logic [SQW-1:0]         sq_q;
  logic                   a_valid_q, a_first_q, a_last_q;
  logic                   b_valid_q, b_first_q, b_last_q;
  logic [IDX_W-1:0]       a_idx_q, b_idx_q, idx_q;
  logic [ACC_W-1:0]       acc_q;
  logic                   done_q;

  assign diff_d     = DIFW'(signed'(feat_i)) - DIFW'(signed'(cb_i));
  assign diff_ext_c = SQW'(diff_q);
  assign prod_c     = diff_ext_c * diff_ext_c;

  // Difference and square stages, with the codeword framing flags alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      a_valid_q <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_idx_q   <= '0;
      sq_q      <= '0;
      b_valid_q <= 1'b0;
      b_first_q <= 1'b0;
      b_last_q  <= 1'b0;
      b_idx_q   <= '0;
    end else begin
      diff_q    <= diff_d;
      a_valid_q <= valid_i;
      a_first_q <= first_i;
      a_last_q  <= last_i;
      a_idx_q   <= idx_i;
      sq_q      <= prod_c;
      b_valid_q <= a_valid_q;
      b_first_q <= a_first_q;
      b_last_q  <= a_last_q;
      b_idx_q   <= a_idx_q;
    end
  end

  // Per-codeword accumulator; the first dimension restarts the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      if (b_valid_q) begin
        acc_q <= b_first_q ? ACC_W'(sq_q) : acc_q + ACC_W'(sq_q);
      end
      done_q <= b_valid_q & b_last_q;
      idx_q  <= b_idx_q;
    end
  end

  assign done_o = done_q;
  assign idx_o  = idx_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/vq_dist_search.sv
// Nearest-codeword search: buffers one feature vector, streams the codebook
// from RAM, tracks the minimum squared distance and per-utterance totals.
module vq_dist_search
  import vq_pkg::*;
#(
  parameter int unsigned NUM_CW  = NUM_CW_DEF,
  parameter int unsigned DIM     = DIM_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = 8,
  parameter int unsigned CB_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              feat_valid,
  input  logic [DW-1:0]     feat_data,
  output logic              feat_ready,
  output logic [AW-1:0]     cb_rd_addr,
  input  logic [DW-1:0]     cb_rd_data,
  output logic              busy,
  output logic              res_valid,
  output logic [IDX_W-1:0]  best_idx,
  output logic [ACC_W-1:0]  best_dist,
  input  logic              sum_clr,
  output logic [SUM_W-1:0]  dist_sum,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned     DCW       = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [AW-1:0]    BASE_ADDR = AW'(CB_BASE);
  localparam logic [DCW-1:0]   D_LAST    = DCW'(DIM - 1);
  localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(NUM_CW - 1);

  vq_state_e          state_q;
  logic               feat_ready_q, busy_q;
  logic [AW-1:0]      addr_q;
  logic [DCW-1:0]     d_q;
  logic [IDX_W-1:0]   k_q;
  logic [DW-1:0]      feat_buf_q [DIM];

  logic               s1_valid_q, s1_first_q, s1_last_q;
  logic [DCW-1:0]     s1_d_q;
  logic [IDX_W-1:0]   s1_k_q;
  logic [DW-1:0]      feat_sel_c;

  logic               acc_done;
  logic [IDX_W-1:0]   acc_idx;
  logic [ACC_W-1:0]   acc_val;
  logic               last_done;

  logic [ACC_W-1:0]   min_dist_q, new_dist_d, best_dist_q;
  logic [IDX_W-1:0]   min_idx_q, new_idx_d, best_idx_q;
  logic               res_valid_q;
  logic [SUM_W-1:0]   dist_sum_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [SUM_W:0]     sum_ext_c;

  logic               accept;

  assign accept    = feat_valid & feat_ready_q;
  assign last_done = acc_done & (acc_idx == K_LAST);

  // Control FSM: d_q is the load pointer in IDLE/LOAD and the dimension in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      feat_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      addr_q       <= BASE_ADDR;
      d_q          <= '0;
      k_q          <= '0;
      for (int i = 0; i < DIM; i++) feat_buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            feat_buf_q[d_q] <= feat_data;
            if (d_q == D_LAST) begin
              state_q      <= CALC;
              feat_ready_q <= 1'b0;
              busy_q       <= 1'b1;
              d_q          <= '0;
            end else begin
              state_q <= LOAD;
              d_q     <= d_q + DCW'(1);
            end
          end
        end
        CALC: begin
          if (d_q == D_LAST) begin
            d_q <= '0;
            if (k_q == K_LAST) begin
              state_q <= DONE;
              k_q     <= '0;
              addr_q  <= BASE_ADDR;
            end else begin
              k_q    <= k_q + IDX_W'(1);
              addr_q <= addr_q + AW'(1);
            end
          end else begin
            d_q    <= d_q + DCW'(1);
            addr_q <= addr_q + AW'(1);
          end
        end
        DONE: begin
          if (last_done) begin
            state_q      <= IDLE;
            feat_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay the address-side tags by one cycle to line up with RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_d_q     <= '0;
      s1_k_q     <= '0;
    end else begin
      s1_valid_q <= (state_q == CALC);
      s1_first_q <= (d_q == '0);
      s1_last_q  <= (d_q == D_LAST);
      s1_d_q     <= d_q;
      s1_k_q     <= k_q;
    end
  end

  assign feat_sel_c = feat_buf_q[s1_d_q];

  vq_sq_acc #(
    .DW (DW)
  ) u_sq_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s1_valid_q),
    .first_i (s1_first_q),
    .last_i  (s1_last_q),
    .idx_i   (s1_k_q),
    .feat_i  (feat_sel_c),
    .cb_i    (cb_rd_data),
    .done_o  (acc_done),
    .idx_o   (acc_idx),
    .acc_o   (acc_val)
  );

  // Strict less-than keeps the lower index on ties; codeword 0 seeds the minimum.
  always_comb begin
    new_dist_d = min_dist_q;
    new_idx_d  = min_idx_q;
    if (acc_done && ((acc_idx == '0) || (acc_val < min_dist_q))) begin
      new_dist_d = acc_val;
      new_idx_d  = acc_idx;
    end
  end

  // Running minimum and the published result, updated with the result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_dist_q  <= '0;
      min_idx_q   <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= last_done;
      if (acc_done) begin
        min_dist_q <= new_dist_d;
        min_idx_q  <= new_idx_d;
      end
      if (last_done) begin
        best_dist_q <= new_dist_d;
        best_idx_q  <= new_idx_d;
      end
    end
  end

  assign sum_ext_c = {1'b0, dist_sum_q} + (SUM_W + 1)'(best_dist_q);

  // Utterance accumulators; a clear takes priority over a coincident result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_sum_q  <= '0;
      frame_cnt_q <= '0;
    end else if (sum_clr) begin
      dist_sum_q  <= '0;
      frame_cnt_q <= '0;
    end else if (res_valid_q) begin
      dist_sum_q <= sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
      if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign feat_ready = feat_ready_q;
  assign busy       = busy_q;
  assign cb_rd_addr = addr_q;
  assign res_valid  = res_valid_q;
  assign best_idx   = best_idx_q;
  assign best_dist  = best_dist_q;
  assign dist_sum   = dist_sum_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
